ctrl_addr_seq: RTL

Parametrised address sequencer that steps a channel/bank address through a programmable range, one address per falling edge of a slow external step strobe. It succeeds the fixed 4-bit wrap-only control-address counter: it adds a programmable first address, wrap / one-shot / ping-pong modes, double-buffered configuration and boundary status pulses. It runs entirely in the clk_sys domain and drives the address bus of the echo-acquisition control path.

---
 rtl/ctrl_addr_seq.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/ctrl_addr_seq.sv
// ---------------------------------------------------------------------------
// ctrl_addr_seq
//
// Address sequencer for the echo-acquisition control path. It steps a
// channel/bank address through a programmable [first, lim] range. The address
// advances once per falling edge of a slow, asynchronous step strobe.
// It supports three modes: wrap, one-shot and ping-pong. The range and mode
// are double-buffered: a load writes the shadow copy only. The active copy
// follows the shadow at a range boundary, on clr, or on a step that arrives
// after a one-shot has finished. A load therefore never disturbs a sequence
// that is in flight.
//
// Ports
//   clk_sys   in   system clock, all logic on the rising edge
//   rst_n     in   asynchronous active-low reset
//   step      in   asynchronous advance strobe, one step per falling edge
//   load      in   capture first_in / lim_in / mode_in into the shadow set
//   first_in  in   first (lowest) address of the range
//   lim_in    in   last (highest) address of the range
//   mode_in   in   00 wrap, 01 one-shot, 10 ping-pong, 11 behaves as 00
//   clr       in   synchronous restart from the shadow configuration
//   addr_out  out  current address
//   dir       out  1 = counting up, 0 = counting down (ping-pong only)
//   wrap_p    out  one-cycle pulse when the address returns to first
//   done      out  level, one-shot range finished
// ---------------------------------------------------------------------------
module ctrl_addr_seq #(
  parameter int AW          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int RST_ADDR    = 1
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          step,
  input  logic          load,
  input  logic [AW-1:0] first_in,
  input  logic [AW-1:0] lim_in,
  input  logic [1:0]    mode_in,
  input  logic          clr,
  output logic [AW-1:0] addr_out,
  output logic          dir,
  output logic          wrap_p,
  output logic          done
);

  localparam logic [AW-1:0] RST_A  = AW'(RST_ADDR);
  localparam logic [AW-1:0] ONE_A  = AW'(1);
  localparam logic [1:0]    MODE_WRAP     = 2'b00;
  localparam logic [1:0]    MODE_ONESHOT  = 2'b01;
  localparam logic [1:0]    MODE_PINGPONG = 2'b10;

  // Step synchroniser and edge detector
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   stp_q, stp_d;

  // Shadow configuration (written by load)
  logic [AW-1:0] first_s_q, first_s_d;
  logic [AW-1:0] lim_s_q,   lim_s_d;
  logic [1:0]    mode_s_q,  mode_s_d;

  // Active configuration (what the sequence actually uses)
  logic [AW-1:0] first_a_q, first_a_d;
  logic [AW-1:0] lim_a_q,   lim_a_d;
  logic [1:0]    mode_a_q,  mode_a_d;

  // Sequencer state / registered outputs
  logic [AW-1:0] addr_q, addr_d;
  logic          dir_q,  dir_d;
  logic          wrap_q, wrap_d;
  logic          done_q, done_d;

  // Helper terms
  logic          reload;
  logic          end_up;
  logic          degen;
  logic          dn_hits_first;
  logic [AW-1:0] addr_inc;
  logic [AW-1:0] addr_dec;

  assign addr_inc = addr_q + ONE_A;
  assign addr_dec = addr_q - ONE_A;

  // ">=" rather than "==" lets an out-of-range address recover on the next step.
  assign end_up = (addr_q >= lim_a_q);
  // An empty or inverted range makes every step a boundary.
  assign degen  = (lim_a_q <= first_a_q);
  // Next downward step would reach (or pass) first. Address 0 is special-cased
  // so the decrement cannot wrap around to the top of the address space.
  assign dn_hits_first = (addr_q == '0) || (addr_dec <= first_a_q);

  always_comb begin
    // Synchroniser shifts step in. stp is one cycle wide, on the registered
    // 1 -> 0 transition of the synchronised strobe.
    sync_d = {sync_q[SYNC_STAGES-2:0], step};
    prev_d = sync_q[SYNC_STAGES-1];
    stp_d  = prev_q & ~sync_q[SYNC_STAGES-1];

    first_s_d = first_s_q;
    lim_s_d   = lim_s_q;
    mode_s_d  = mode_s_q;
    if (load) begin
      first_s_d = first_in;
      lim_s_d   = lim_in;
      mode_s_d  = mode_in;
    end

    addr_d = addr_q;
    dir_d  = dir_q;
    done_d = done_q;
    wrap_d = 1'b0;
    reload = 1'b0;

    if (clr) begin
      // clr takes priority over a coincident step, and the step is dropped.
      addr_d = first_s_q;
      dir_d  = 1'b1;
      done_d = 1'b0;
      reload = 1'b1;
    end else if (stp_q) begin
      if (done_q) begin
        // A finished one-shot ignores steps. It only picks up new config.
        reload = 1'b1;
      end else begin
        case (mode_a_q)
          MODE_ONESHOT: begin
            if (end_up || degen) begin
              done_d = 1'b1;
            end else begin
              addr_d = addr_inc;
            end
          end
          MODE_PINGPONG: begin
            if (degen || (dir_q ? (end_up && dn_hits_first) : dn_hits_first)) begin
              // Arrival at first closes one ping-pong period.
              addr_d = first_s_q;
              dir_d  = 1'b1;
              wrap_d = 1'b1;
              reload = 1'b1;
            end else if (dir_q && end_up) begin
              dir_d  = 1'b0;
              addr_d = addr_dec;
            end else if (dir_q) begin
              addr_d = addr_inc;
            end else begin
              addr_d = addr_dec;
            end
          end
          default: begin
            // Wrap (mode 00, and the reserved encoding 11)
            if (end_up || degen) begin
              addr_d = first_s_q;
              dir_d  = 1'b1;
              wrap_d = 1'b1;
              reload = 1'b1;
            end else begin
              addr_d = addr_inc;
            end
          end
        endcase
      end
    end

    // The reload uses the shadow value held before this edge, so a load that
    // coincides with a boundary takes effect at the following boundary.
    first_a_d = first_a_q;
    lim_a_d   = lim_a_q;
    mode_a_d  = mode_a_q;
    if (reload) begin
      first_a_d = first_s_q;
      lim_a_d   = lim_s_q;
      mode_a_d  = mode_s_q;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      // The synchroniser resets to the idle-high level, so a step edge that is
      // in flight during reset is discarded.
      sync_q    <= '1;
      prev_q    <= 1'b1;
      stp_q     <= 1'b0;
      first_s_q <= RST_A;
      lim_s_q   <= RST_A;
      mode_s_q  <= MODE_WRAP;
      first_a_q <= RST_A;
      lim_a_q   <= RST_A;
      mode_a_q  <= MODE_WRAP;
      addr_q    <= RST_A;
      dir_q     <= 1'b1;
      wrap_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      stp_q     <= stp_d;
      first_s_q <= first_s_d;
      lim_s_q   <= lim_s_d;
      mode_s_q  <= mode_s_d;
      first_a_q <= first_a_d;
      lim_a_q   <= lim_a_d;
      mode_a_q  <= mode_a_d;
      addr_q    <= addr_d;
      dir_q     <= dir_d;
      wrap_q    <= wrap_d;
      done_q    <= done_d;
    end
  end

  assign addr_out = addr_q;
  assign dir      = dir_q;
  assign wrap_p   = wrap_q;
  assign done     = done_q;

endmodule
